control_unit_legv8: RTL and testbench

- Multi-cycle control unit for the LEGv8 datapath.
- Holds a small fetch/execute state machine and decodes the 32-bit instruction word. Each cycle it produces a 34-bit ControlWord that drives the register file, ALU, data memory, PC unit and instruction register.
- Produces the 64-bit extended immediate (`constant`) for the datapath B-mux and PC unit.
- Consumes live/stored status flags to resolve conditional branches.

---
 rtl/legv8_ctrl_pkg.sv | 108 ++++++++++
 rtl/legv8_imm_gen.sv | 33 +++
 rtl/control_unit_legv8.sv | 167 ++++++++++++++++
 tb/tb_control_unit_legv8.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared constants for the LEGv8 multi-cycle control unit: state encodings,
// ControlWord field positions, ALU/PC codes, opcodes and the condition evaluator.
package legv8_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_EXEC2 = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE    = 3'd0,
        IMM_SHAMT   = 3'd1,
        IMM_ALU12   = 3'd2,
        IMM_DT9     = 3'd3,
        IMM_MOVW    = 3'd4,
        IMM_MOVMASK = 3'd5,
        IMM_BR26    = 3'd6,
        IMM_CB19    = 3'd7
    } imm_fmt_t;

    localparam int CW_DA_LO   = 29;
    localparam int CW_SA_LO   = 24;
    localparam int CW_SB_LO   = 19;
    localparam int CW_FS_LO   = 14;
    localparam int CW_BSEL    = 13;
    localparam int CW_RW      = 12;
    localparam int CW_MW      = 11;
    localparam int CW_EN_ALU  = 10;
    localparam int CW_EN_MEM  = 9;
    localparam int CW_EN_PC   = 8;
    localparam int CW_PS_LO   = 6;
    localparam int CW_SL      = 5;
    localparam int CW_C0      = 4;
    localparam int CW_IL      = 3;
    localparam int CW_NS_LO   = 1;
    localparam int CW_RSVD    = 0;

    localparam logic [2:0] FS_AND    = 3'b000;
    localparam logic [2:0] FS_OR     = 3'b001;
    localparam logic [2:0] FS_ADD    = 3'b010;
    localparam logic [2:0] FS_XOR    = 3'b011;
    localparam logic [2:0] FS_LSL    = 3'b100;
    localparam logic [2:0] FS_LSR    = 3'b101;
    localparam logic [2:0] FS_PASS_B = 3'b110;
    localparam logic [2:0] FS_PASS_A = 3'b111;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BRANCH = 2'b10;
    localparam logic [1:0] PS_REG    = 2'b11;

    localparam logic [10:0] OPC_ADD   = 11'b10001011000;
    localparam logic [10:0] OPC_SUB   = 11'b11001011000;
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [10:0] OPC_AND   = 11'b10001010000;
    localparam logic [10:0] OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] OPC_EOR   = 11'b11001010000;
    localparam logic [10:0] OPC_ANDS  = 11'b11101010000;
    localparam logic [10:0] OPC_LSR   = 11'b11010011010;
    localparam logic [10:0] OPC_LSL   = 11'b11010011011;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_BR    = 11'b11010110000;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OPC_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OPC_SUBIS = 10'b1111000100;
    localparam logic [9:0]  OPC_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OPC_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OPC_EORI  = 10'b1101001000;
    localparam logic [9:0]  OPC_ANDIS = 10'b1111001000;
    localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OPC_MOVK  = 9'b111100101;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [5:0]  OPC_BL    = 6'b100101;

    // flags = {V, N, C, Z}; returns 1 when the ARM condition code holds
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic v, n, c, z, r;
        {v, n, c, z} = flags;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = ~(n ^ v);
            4'b1011: r = n ^ v;
            4'b1100: r = ~z & ~(n ^ v);
            4'b1101: r = z | (n ^ v);
            4'b1110: r = 1'b1;
            4'b1111: r = 1'b1;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate generator: extracts, extends and positions the instruction
// immediate selected by the decoder into the 64-bit datapath constant.
module legv8_imm_gen
    import legv8_ctrl_pkg::*;
(
    input  logic [25:0] field,
    input  imm_fmt_t    fmt,
    output logic [63:0] imm
);

    logic [5:0]  hw_shift_s;
    logic [63:0] imm16_s;

    assign hw_shift_s = {field[22:21], 4'b0000};
    assign imm16_s    = {48'd0, field[20:5]};

    // Format-driven immediate extraction
    always_comb begin
        imm = 64'd0;
        case (fmt)
            IMM_SHAMT:   imm = {58'd0, field[15:10]};
            IMM_ALU12:   imm = {52'd0, field[21:10]};
            IMM_DT9:     imm = {{55{field[20]}}, field[20:12]};
            IMM_MOVW:    imm = imm16_s << hw_shift_s;
            IMM_MOVMASK: imm = ~(64'h0000_0000_0000_FFFF << hw_shift_s);
            IMM_BR26:    imm = {{38{field[25]}}, field[25:0]};
            IMM_CB19:    imm = {{45{field[23]}}, field[23:5]};
            IMM_NONE:    imm = 64'd0;
            default:     imm = 64'd0;
        endcase
    end

endmodule

// File: rtl/control_unit_legv8.sv
// LEGv8 multi-cycle control unit: FETCH/EXEC(/EXEC2 for MOVK) sequencer and
// instruction decoder producing the 34-bit ControlWord and 64-bit constant.
module control_unit_legv8
    import legv8_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [33:0] ControlWord,
    output logic [63:0] constant,
    input  logic [31:0] instruction,
    input  logic [4:0]  status
);

    state_t     state_r, ns_s;
    imm_fmt_t   fmt_s;
    logic [4:0] da_s, sa_s, sb_s, fs_s;
    logic [1:0] ps_s;
    logic       bsel_s, rw_s, mw_s, en_alu_s, en_mem_s, en_pc_s, sl_s, c0_s, il_s;
    logic [33:0] cw_s;
    logic [63:0] imm_s;
    logic [10:0] op11_s;
    logic [9:0]  op10_s;
    logic [8:0]  op9_s;
    logic [7:0]  op8_s;
    logic [5:0]  op6_s;

    assign op11_s = instruction[31:21];
    assign op10_s = instruction[31:22];
    assign op9_s  = instruction[31:23];
    assign op8_s  = instruction[31:24];
    assign op6_s  = instruction[31:26];

    legv8_imm_gen u_imm_gen (
        .field (instruction[25:0]),
        .fmt   (fmt_s),
        .imm   (imm_s)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= ns_s;
        end
    end

    // Next state and per-field decode
    always_comb begin
        da_s = 5'd0;      sa_s = 5'd0;      sb_s = 5'd0;     fs_s = 5'd0;
        bsel_s = 1'b0;    rw_s = 1'b0;      mw_s = 1'b0;
        en_alu_s = 1'b0;  en_mem_s = 1'b0;  en_pc_s = 1'b0;
        ps_s = PS_HOLD;   sl_s = 1'b0;      c0_s = 1'b0;     il_s = 1'b0;
        ns_s = ST_FETCH;  fmt_s = IMM_NONE;
        case (state_r)
            ST_FETCH: begin
                il_s = 1'b1;
                ns_s = ST_EXEC;
            end
            ST_EXEC: begin
                da_s = instruction[4:0];
                sa_s = instruction[9:5];
                sb_s = instruction[20:16];
                ps_s = PS_INC;
                if (op11_s == OPC_ADD || op11_s == OPC_ADDS) begin
                    fs_s = {FS_ADD, 2'b00};  en_alu_s = 1'b1;  rw_s = 1'b1;
                    sl_s = (op11_s == OPC_ADDS);
                end else if (op11_s == OPC_SUB || op11_s == OPC_SUBS) begin
                    fs_s = {FS_ADD, 2'b01};  c0_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;
                    sl_s = (op11_s == OPC_SUBS);
                end else if (op11_s == OPC_AND || op11_s == OPC_ANDS) begin
                    fs_s = {FS_AND, 2'b00};  en_alu_s = 1'b1;  rw_s = 1'b1;
                    sl_s = (op11_s == OPC_ANDS);
                end else if (op11_s == OPC_ORR || op11_s == OPC_EOR) begin
                    fs_s = (op11_s == OPC_ORR) ? {FS_OR, 2'b00} : {FS_XOR, 2'b00};
                    en_alu_s = 1'b1;  rw_s = 1'b1;
                end else if (op11_s == OPC_LSR || op11_s == OPC_LSL) begin
                    fs_s = (op11_s == OPC_LSR) ? {FS_LSR, 2'b00} : {FS_LSL, 2'b00};
                    bsel_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;  fmt_s = IMM_SHAMT;
                end else if (op10_s == OPC_ADDI || op10_s == OPC_ADDIS) begin
                    fs_s = {FS_ADD, 2'b00};  bsel_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;
                    sl_s = (op10_s == OPC_ADDIS);  fmt_s = IMM_ALU12;
                end else if (op10_s == OPC_SUBI || op10_s == OPC_SUBIS) begin
                    fs_s = {FS_ADD, 2'b01};  c0_s = 1'b1;  bsel_s = 1'b1;  en_alu_s = 1'b1;
                    rw_s = 1'b1;  sl_s = (op10_s == OPC_SUBIS);  fmt_s = IMM_ALU12;
                end else if (op10_s == OPC_ANDI || op10_s == OPC_ANDIS) begin
                    fs_s = {FS_AND, 2'b00};  bsel_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;
                    sl_s = (op10_s == OPC_ANDIS);  fmt_s = IMM_ALU12;
                end else if (op10_s == OPC_ORRI || op10_s == OPC_EORI) begin
                    fs_s = (op10_s == OPC_ORRI) ? {FS_OR, 2'b00} : {FS_XOR, 2'b00};
                    bsel_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;  fmt_s = IMM_ALU12;
                end else if (op11_s == OPC_LDUR) begin
                    fs_s = {FS_ADD, 2'b00};  bsel_s = 1'b1;  en_mem_s = 1'b1;  rw_s = 1'b1;
                    fmt_s = IMM_DT9;
                end else if (op11_s == OPC_STUR) begin
                    sb_s = instruction[4:0];  fs_s = {FS_ADD, 2'b00};  bsel_s = 1'b1;
                    mw_s = 1'b1;  fmt_s = IMM_DT9;
                end else if (op11_s == OPC_BR) begin
                    ps_s = PS_REG;
                end else if (op9_s == OPC_MOVZ) begin
                    fs_s = {FS_PASS_B, 2'b00};  bsel_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;
                    fmt_s = IMM_MOVW;
                end else if (op9_s == OPC_MOVK) begin
                    // First half of MOVK clears the target halfword
                    sa_s = instruction[4:0];  fs_s = {FS_AND, 2'b00};  bsel_s = 1'b1;
                    en_alu_s = 1'b1;  rw_s = 1'b1;  fmt_s = IMM_MOVMASK;  ns_s = ST_EXEC2;
                end else if (op8_s == OPC_CBZ || op8_s == OPC_CBNZ) begin
                    sa_s = instruction[4:0];  fs_s = {FS_PASS_A, 2'b00};  fmt_s = IMM_CB19;
                    ps_s = (status[4] == (op8_s == OPC_CBZ)) ? PS_BRANCH : PS_INC;
                end else if (op8_s == OPC_BCOND) begin
                    fmt_s = IMM_CB19;
                    ps_s  = cond_holds(instruction[3:0], status[3:0]) ? PS_BRANCH : PS_INC;
                end else if (op6_s == OPC_B || op6_s == OPC_BL) begin
                    ps_s = PS_BRANCH;  fmt_s = IMM_BR26;
                    if (op6_s == OPC_BL) begin
                        da_s = 5'd30;  en_pc_s = 1'b1;  rw_s = 1'b1;
                    end else begin
                        en_pc_s = 1'b0;
                    end
                end else begin
                    rw_s = 1'b0;
                end
            end
            ST_EXEC2: begin
                da_s = instruction[4:0];  sa_s = instruction[4:0];
                fs_s = {FS_OR, 2'b00};  bsel_s = 1'b1;  en_alu_s = 1'b1;  rw_s = 1'b1;
                ps_s = PS_INC;  fmt_s = IMM_MOVW;
            end
            default: begin
                ns_s = ST_FETCH;
            end
        endcase
    end

    // Pack decoded fields into the ControlWord layout
    always_comb begin
        cw_s = 34'd0;
        cw_s[CW_DA_LO +: 5] = da_s;
        cw_s[CW_SA_LO +: 5] = sa_s;
        cw_s[CW_SB_LO +: 5] = sb_s;
        cw_s[CW_FS_LO +: 5] = fs_s;
        cw_s[CW_BSEL]       = bsel_s;
        cw_s[CW_RW]         = rw_s;
        cw_s[CW_MW]         = mw_s;
        cw_s[CW_EN_ALU]     = en_alu_s;
        cw_s[CW_EN_MEM]     = en_mem_s;
        cw_s[CW_EN_PC]      = en_pc_s;
        cw_s[CW_PS_LO +: 2] = ps_s;
        cw_s[CW_SL]         = sl_s;
        cw_s[CW_C0]         = c0_s;
        cw_s[CW_IL]         = il_s;
        cw_s[CW_NS_LO +: 2] = ns_s;
        cw_s[CW_RSVD]       = 1'b0;
    end

    // Outputs are forced to zero while reset is held low
    always_comb begin
        if (!reset) begin
            ControlWord = 34'd0;
            constant    = 64'd0;
        end else begin
            ControlWord = cw_s;
            constant    = imm_s;
        end
    end

endmodule

// File: tb/tb_control_unit_legv8.sv
// Randomised scoreboard bench for control_unit_legv8: a mnemonic-level model
// predicts each cycle's ControlWord/constant; a negedge monitor compares.
module tb_control_unit_legv8;

    logic        clock = 1'b0;
    logic        reset;
    logic [33:0] ControlWord;
    logic [63:0] constant;
    logic [31:0] instruction;
    logic [4:0]  status;

    always #5 clock = ~clock;

    control_unit_legv8 dut (
        .clock       (clock),
        .reset       (reset),
        .ControlWord (ControlWord),
        .constant    (constant),
        .instruction (instruction),
        .status      (status)
    );

    localparam int M_ADD = 0,  M_SUB = 1,  M_ADDS = 2,  M_SUBS = 3,  M_AND = 4,  M_ORR = 5;
    localparam int M_EOR = 6,  M_ANDS = 7, M_LSR = 8,   M_LSL = 9,   M_ADDI = 10, M_SUBI = 11;
    localparam int M_ADDIS = 12, M_SUBIS = 13, M_ANDI = 14, M_ORRI = 15, M_EORI = 16;
    localparam int M_ANDIS = 17, M_LDUR = 18, M_STUR = 19, M_MOVZ = 20, M_MOVK = 21;
    localparam int M_B = 22, M_BL = 23, M_BR = 24, M_CBZ = 25, M_CBNZ = 26, M_BCOND = 27;
    localparam int M_NOP = 28;

    localparam int P_DA = 29, P_SA = 24, P_SB = 19, P_FS = 14, P_BSEL = 13, P_RW = 12;
    localparam int P_MW = 11, P_EA = 10, P_EM = 9, P_EP = 8, P_PS = 6, P_SL = 5, P_C0 = 4;
    localparam int P_IL = 3, P_NS = 1, P_R = 0;

    typedef struct {
        int          mn;
        logic [4:0]  rd, rn, rm;
        logic [5:0]  sh;
        logic [11:0] i12;
        logic [8:0]  a9;
        logic [1:0]  hw;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [18:0] i19;
        logic [3:0]  cond;
    } ins_t;

    typedef struct {
        logic [33:0] cw;
        logic [33:0] mask;
        logic [63:0] k;
        logic        kcare;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic ins_t rand_ins(input int mn);
        ins_t x;
        x.mn = mn;  x.rd = 5'($urandom);  x.rn = 5'($urandom);  x.rm = 5'($urandom);
        x.sh = 6'($urandom);  x.i12 = 12'($urandom);  x.a9 = 9'($urandom);
        x.hw = 2'($urandom);  x.i16 = 16'($urandom);  x.i26 = 26'($urandom);
        x.i19 = 19'($urandom);  x.cond = 4'($urandom);
        return x;
    endfunction

    function automatic logic [31:0] assemble(input ins_t x);
        logic [31:0] w;
        case (x.mn)
            M_ADD:   w = {11'b10001011000, x.rm, x.sh, x.rn, x.rd};
            M_SUB:   w = {11'b11001011000, x.rm, x.sh, x.rn, x.rd};
            M_ADDS:  w = {11'b10101011000, x.rm, x.sh, x.rn, x.rd};
            M_SUBS:  w = {11'b11101011000, x.rm, x.sh, x.rn, x.rd};
            M_AND:   w = {11'b10001010000, x.rm, x.sh, x.rn, x.rd};
            M_ORR:   w = {11'b10101010000, x.rm, x.sh, x.rn, x.rd};
            M_EOR:   w = {11'b11001010000, x.rm, x.sh, x.rn, x.rd};
            M_ANDS:  w = {11'b11101010000, x.rm, x.sh, x.rn, x.rd};
            M_LSR:   w = {11'b11010011010, x.rm, x.sh, x.rn, x.rd};
            M_LSL:   w = {11'b11010011011, x.rm, x.sh, x.rn, x.rd};
            M_ADDI:  w = {10'b1001000100, x.i12, x.rn, x.rd};
            M_SUBI:  w = {10'b1101000100, x.i12, x.rn, x.rd};
            M_ADDIS: w = {10'b1011000100, x.i12, x.rn, x.rd};
            M_SUBIS: w = {10'b1111000100, x.i12, x.rn, x.rd};
            M_ANDI:  w = {10'b1001001000, x.i12, x.rn, x.rd};
            M_ORRI:  w = {10'b1011001000, x.i12, x.rn, x.rd};
            M_EORI:  w = {10'b1101001000, x.i12, x.rn, x.rd};
            M_ANDIS: w = {10'b1111001000, x.i12, x.rn, x.rd};
            M_LDUR:  w = {11'b11111000010, x.a9, 2'b00, x.rn, x.rd};
            M_STUR:  w = {11'b11111000000, x.a9, 2'b00, x.rn, x.rd};
            M_MOVZ:  w = {9'b110100101, x.hw, x.i16, x.rd};
            M_MOVK:  w = {9'b111100101, x.hw, x.i16, x.rd};
            M_B:     w = {6'b000101, x.i26};
            M_BL:    w = {6'b100101, x.i26};
            M_BR:    w = {11'b11010110000, 5'b11111, 6'b000000, x.rn, 5'b00000};
            M_CBZ:   w = {8'b10110100, x.i19, x.rd};
            M_CBNZ:  w = {8'b10110101, x.i19, x.rd};
            M_BCOND: w = {8'b01010100, x.i19, 1'b0, x.cond};
            default: w = {8'h00, x.i16, x.rd, x.hw, 1'b0};
        endcase
        return w;
    endfunction

    function automatic exp_t put(input exp_t e, input int lo, input int w, input int val);
        exp_t r;
        r = e;
        for (int i = 0; i < w; i++) begin
            r.cw[lo + i]   = val[i];
            r.mask[lo + i] = 1'b1;
        end
        return r;
    endfunction

    function automatic bit cond_taken(input logic [3:0] c, input logic [4:0] st);
        bit z, cf, n, v, r;
        z = st[0];  cf = st[1];  n = st[2];  v = st[3];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    // phase: 0 FETCH, 1 EXEC, 2 EXEC2, 3 reset held low
    function automatic exp_t model(input ins_t x, input int phase, input logic [4:0] st);
        exp_t e;
        int op, sb, s, kind;
        longint sv;
        e.cw = '0;  e.mask = '0;  e.k = '0;  e.kcare = 1'b0;  e.tag = x.mn * 4 + phase;
        if (phase == 3) begin
            e.mask = '1;  e.kcare = 1'b1;
            return e;
        end
        if (phase == 0) begin
            e = put(e, P_IL, 1, 1);  e = put(e, P_PS, 2, 0);  e = put(e, P_NS, 2, 1);
            e = put(e, P_RW, 1, 0);  e = put(e, P_MW, 1, 0);
            return e;
        end
        e = put(e, P_IL, 1, 0);  e = put(e, P_R, 1, 0);   e = put(e, P_MW, 1, 0);
        e = put(e, P_SL, 1, 0);  e = put(e, P_RW, 1, 0);  e = put(e, P_EM, 1, 0);
        e = put(e, P_EP, 1, 0);  e = put(e, P_PS, 2, 1);  e = put(e, P_NS, 2, 0);
        op = -1;  sb = 0;  s = 0;  kind = 0;
        case (x.mn)
            M_ADD:   op = 2;
            M_SUB:   begin op = 2; sb = 1; end
            M_ADDS:  begin op = 2; s = 1; end
            M_SUBS:  begin op = 2; sb = 1; s = 1; end
            M_AND:   op = 0;
            M_ORR:   op = 1;
            M_EOR:   op = 3;
            M_ANDS:  begin op = 0; s = 1; end
            M_LSR:   begin op = 5; kind = 1; end
            M_LSL:   begin op = 4; kind = 1; end
            M_ADDI:  begin op = 2; kind = 2; end
            M_SUBI:  begin op = 2; sb = 1; kind = 2; end
            M_ADDIS: begin op = 2; s = 1; kind = 2; end
            M_SUBIS: begin op = 2; sb = 1; s = 1; kind = 2; end
            M_ANDI:  begin op = 0; kind = 2; end
            M_ORRI:  begin op = 1; kind = 2; end
            M_EORI:  begin op = 3; kind = 2; end
            M_ANDIS: begin op = 0; s = 1; kind = 2; end
            default: op = -1;
        endcase
        if (op >= 0) begin
            e = put(e, P_DA, 5, int'(x.rd));  e = put(e, P_SA, 5, int'(x.rn));
            e = put(e, P_FS, 5, op * 4 + sb);  e = put(e, P_BSEL, 1, (kind != 0) ? 1 : 0);
            e = put(e, P_EA, 1, 1);  e = put(e, P_RW, 1, 1);  e = put(e, P_SL, 1, s);
            if (op == 2) e = put(e, P_C0, 1, sb);
            if (kind == 0) e = put(e, P_SB, 5, int'(x.rm));
            if (kind == 1) begin e.k = 64'(x.sh);  e.kcare = 1'b1; end
            if (kind == 2) begin e.k = 64'(x.i12); e.kcare = 1'b1; end
            return e;
        end
        case (x.mn)
            M_LDUR, M_STUR: begin
                sv = $signed(x.a9);  e.k = sv;  e.kcare = 1'b1;
                e = put(e, P_SA, 5, int'(x.rn));  e = put(e, P_FS, 5, 8);  e = put(e, P_BSEL, 1, 1);
                if (x.mn == M_LDUR) begin
                    e = put(e, P_DA, 5, int'(x.rd));  e = put(e, P_EM, 1, 1);
                    e = put(e, P_RW, 1, 1);  e = put(e, P_EA, 1, 0);
                end else begin
                    e = put(e, P_SB, 5, int'(x.rd));  e = put(e, P_MW, 1, 1);
                end
            end
            M_MOVZ: begin
                e.k = 64'(x.i16) << (16 * x.hw);  e.kcare = 1'b1;
                e = put(e, P_DA, 5, int'(x.rd));  e = put(e, P_FS, 5, 24);  e = put(e, P_BSEL, 1, 1);
                e = put(e, P_RW, 1, 1);  e = put(e, P_EA, 1, 1);
            end
            M_MOVK: begin
                e.kcare = 1'b1;
                e = put(e, P_DA, 5, int'(x.rd));  e = put(e, P_SA, 5, int'(x.rd));
                e = put(e, P_BSEL, 1, 1);  e = put(e, P_RW, 1, 1);  e = put(e, P_EA, 1, 1);
                if (phase == 1) begin
                    e.k = ~(64'hFFFF << (16 * x.hw));
                    e = put(e, P_FS, 5, 0);  e = put(e, P_NS, 2, 2);
                end else begin
                    e.k = 64'(x.i16) << (16 * x.hw);
                    e = put(e, P_FS, 5, 4);
                end
            end
            M_B, M_BL: begin
                sv = $signed(x.i26);  e.k = sv;  e.kcare = 1'b1;
                e = put(e, P_PS, 2, 2);
                if (x.mn == M_BL) begin
                    e = put(e, P_DA, 5, 30);  e = put(e, P_EP, 1, 1);
                    e = put(e, P_RW, 1, 1);   e = put(e, P_EA, 1, 0);
                end
            end
            M_BR: begin
                e = put(e, P_SA, 5, int'(x.rn));  e = put(e, P_PS, 2, 3);
            end
            M_CBZ, M_CBNZ: begin
                sv = $signed(x.i19);  e.k = sv;  e.kcare = 1'b1;
                e = put(e, P_SA, 5, int'(x.rd));  e = put(e, P_FS, 5, 28);
                e = put(e, P_PS, 2, ((st[4] == 1'b1) == (x.mn == M_CBZ)) ? 2 : 1);
            end
            M_BCOND: begin
                sv = $signed(x.i19);  e.k = sv;  e.kcare = 1'b1;
                e = put(e, P_PS, 2, cond_taken(x.cond, st) ? 2 : 1);
            end
            default: e.kcare = 1'b0;
        endcase
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic [31:0] ins, input logic [4:0] st, input exp_t e);
        @(posedge clock);
        #1;
        reset = rst;  instruction = ins;  status = st;
        sbq.push_back(e);
    endtask

    task automatic run_instr(input ins_t x, input bit fix, input logic [4:0] fst);
        logic [31:0] w;
        logic [4:0]  st;
        w  = assemble(x);
        st = 5'($urandom);
        cycle(1'b1, $urandom, st, model(x, 0, st));
        st = fix ? fst : 5'($urandom);
        cycle(1'b1, w, st, model(x, 1, st));
        if (x.mn == M_MOVK) begin
            st = 5'($urandom);
            cycle(1'b1, w, st, model(x, 2, st));
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ((ControlWord & e.mask) !== (e.cw & e.mask)) begin
                    failures++;
                    $display("FAIL cw tag=%0d got=%h exp=%h mask=%h", e.tag, ControlWord, e.cw, e.mask);
                end
                if (e.kcare) begin
                    checks++;
                    if (constant !== e.k) begin
                        failures++;
                        $display("FAIL constant tag=%0d got=%h exp=%h", e.tag, constant, e.k);
                    end
                end
            end
        end
    end

    initial begin
        ins_t x;
        int   guard;
        reset = 1'b0;  instruction = 32'd0;  status = 5'd0;
        x = rand_ins(M_ADD);
        cycle(1'b0, $urandom, 5'($urandom), model(x, 3, 5'd0));
        cycle(1'b0, $urandom, 5'($urandom), model(x, 3, 5'd0));

        x = rand_ins(M_MOVZ); x.rd = 5'd1; x.hw = 2'd0; x.i16 = 16'd1;       run_instr(x, 1'b0, 5'd0);
        x.rd = 5'd2; x.hw = 2'd1;                                             run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_ADD);  x.rd = 5'd4;  x.rn = 5'd1; x.rm = 5'd2; x.sh = 6'd0; run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_SUBS); x.rd = 5'd31; x.rn = 5'd1; x.rm = 5'd2; x.sh = 6'd0; run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_STUR); x.rd = 5'd4;  x.rn = 5'd31; x.a9 = 9'd16;       run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_LDUR); x.rd = 5'd5;  x.rn = 5'd31; x.a9 = 9'd16;       run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_B);    x.i26 = 26'h3FF_FFF9;                           run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_BL);   x.i26 = 26'd10;                                 run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_BR);   x.rn = 5'd30;                                   run_instr(x, 1'b0, 5'd0);
        x = rand_ins(M_BCOND); x.i19 = 19'd1; x.cond = 4'b0011;               run_instr(x, 1'b1, 5'b00000);
        run_instr(x, 1'b1, 5'b00010);
        x.cond = 4'b0100;                                                     run_instr(x, 1'b1, 5'b00100);
        x.cond = 4'b1111;                                                     run_instr(x, 1'b1, 5'b01111);
        x = rand_ins(M_CBZ);  x.rd = 5'd1; x.i19 = 19'd3;                     run_instr(x, 1'b1, 5'b10000);
        run_instr(x, 1'b1, 5'b00000);
        x = rand_ins(M_CBNZ);                                                 run_instr(x, 1'b1, 5'b10000);
        x = rand_ins(M_MOVK); x.rd = 5'd7; x.hw = 2'd1; x.i16 = 16'd5;        run_instr(x, 1'b0, 5'd0);

        // reset while MOVK is in EXEC: must return to FETCH, not EXEC2
        cycle(1'b1, $urandom, 5'($urandom), model(x, 0, 5'd0));
        cycle(1'b0, assemble(x), 5'($urandom), model(x, 3, 5'd0));

        for (int i = 0; i < 400; i++) begin
            x = rand_ins($urandom_range(0, 28));
            run_instr(x, 1'b0, 5'd0);
        end

        guard = 0;
        while (sbq.size() > 0 && guard < 20) begin
            @(posedge clock);
            guard++;
        end
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
